formula_pipe_out_buffer: RTL and testbench

FORMULA_PIPE_OUT_BUFFER -- requirements
Module: formula_pipe_out_buffer

---
 rtl/formula_pipe_pkg.sv | 7 +
 rtl/formula_pipe_out_buffer_if.sv | 32 +++
 rtl/formula_fifo.sv | 61 ++++++
 rtl/formula_pipe_out_buffer.sv | 75 +++++++
 tb/tb_formula_pipe_out_buffer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/formula_pipe_pkg.sv
// Shared defaults for the formula-pipe result buffer: data width and slot count.
package formula_pipe_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/formula_pipe_out_buffer_if.sv
// Bundle of the issue, result and output handshakes around the result buffer.
interface formula_pipe_out_buffer_if
  import formula_pipe_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int LW = $clog2(DEPTH + 1);

  logic          up_vld;
  logic          up_rdy;
  logic          pipe_arg_vld;
  logic          res_vld;
  logic [W-1:0]  res;
  logic          out_vld;
  logic          out_rdy;
  logic [W-1:0]  out_data;
  logic [LW-1:0] level;
  logic          err_ovf;
  logic          err_orphan;

  modport master (
    input  up_vld, res_vld, res, out_rdy,
    output up_rdy, pipe_arg_vld, out_vld, out_data, level, err_ovf, err_orphan
  );

  modport slave (
    output up_vld, res_vld, res, out_rdy,
    input  up_rdy, pipe_arg_vld, out_vld, out_data, level, err_ovf, err_orphan
  );

endinterface

// File: rtl/formula_fifo.sv
// Result storage: circular buffer with occupancy count and a registered head entry.
module formula_fifo
  import formula_pipe_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [W-1:0]  head_nxt;
  logic [LW-1:0] level_nxt;

  // DEPTH is a power of two, so pointer increments wrap on their own
  assign rd_ptr_nxt = rd_ptr + PW'(1);

  always_comb begin
    level_nxt = level;
    head_nxt  = head;
    if (push && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !push)
      level_nxt = level - LW'(1);
    // the head register must already hold the next entry when the pointer moves
    if (pop)
      head_nxt = (level == LW'(1)) ? wdata : mem[rd_ptr_nxt];
    else if (push && level == '0)
      head_nxt = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      level <= level_nxt;
      head  <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/formula_pipe_out_buffer.sv
// Credit-gated issue into a formula pipe with an in-order result buffer and
// sticky overflow / orphan-result error flags.
module formula_pipe_out_buffer
  import formula_pipe_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic                      clk,
  input logic                      rst,
  formula_pipe_out_buffer_if.master bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW:0] SLOTS = (LW + 1)'(DEPTH);

  logic [LW-1:0] level;
  logic [LW-1:0] in_flight;
  logic [LW:0]   committed;
  logic [W-1:0]  head;
  logic          issue;
  logic          push;
  logic          pop;
  logic          full;
  logic          out_vld;
  logic          err_ovf;
  logic          err_orphan;

  // every issued argument owns a slot until its result is popped
  assign committed = {1'b0, level} + {1'b0, in_flight};
  assign bus.up_rdy = rst && (committed < SLOTS);
  assign issue = bus.up_vld && bus.up_rdy;
  assign bus.pipe_arg_vld = issue;

  assign full    = (level == LW'(DEPTH));
  assign out_vld = (level != '0);
  assign pop     = out_vld && bus.out_rdy;
  assign push    = bus.res_vld && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight  <= '0;
      err_ovf    <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (issue && !bus.res_vld)
        in_flight <= in_flight + LW'(1);
      else if (!issue && bus.res_vld && in_flight != '0)
        in_flight <= in_flight - LW'(1);
      if (bus.res_vld && full && !pop)
        err_ovf <= 1'b1;
      if (bus.res_vld && in_flight == '0)
        err_orphan <= 1'b1;
    end
  end

  formula_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (bus.res),
    .pop   (pop),
    .head  (head),
    .level (level)
  );

  assign bus.out_vld    = out_vld;
  assign bus.out_data   = head;
  assign bus.level      = level;
  assign bus.err_ovf    = err_ovf;
  assign bus.err_orphan = err_orphan;

endmodule

// File: tb/tb_formula_pipe_out_buffer.sv
// Directed bench: DEPTH=4 buffer in front of a 3-cycle formula pipe model.
module tb_formula_pipe_out_buffer;
  import formula_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        inj_vld;
  logic [31:0] inj_res;
  logic [31:0] arg_data;
  logic [2:0]  p_vld;
  logic [31:0] p_dat [3];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_iss;
  int          exp_val;
  logic        found;
  logic [31:0] drain_exp [4] = '{32'd23, 32'd24, 32'h0BAD, 32'h0C0D};

  formula_pipe_out_buffer_if #(.W(32), .DEPTH(4)) bus ();

  formula_pipe_out_buffer #(.W(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // formula pipe model: result = argument, three cycles after issue
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_vld    <= '0;
      arg_data <= 32'd1;
    end else begin
      p_vld    <= {p_vld[1:0], bus.pipe_arg_vld};
      p_dat[0] <= arg_data;
      p_dat[1] <= p_dat[0];
      p_dat[2] <= p_dat[1];
      if (bus.pipe_arg_vld) arg_data <= arg_data + 32'd1;
    end
  end

  assign bus.res_vld = p_vld[2] | inj_vld;
  assign bus.res     = inj_vld ? inj_res : p_dat[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; bus.up_vld = 1'b1; bus.out_rdy = 1'b0; inj_vld = 1'b0; inj_res = '0;
    #3;
    check("rst_up_rdy",       32'(bus.up_rdy),       32'd0);
    check("rst_pipe_arg_vld", 32'(bus.pipe_arg_vld), 32'd0);
    check("rst_out_vld",      32'(bus.out_vld),      32'd0);
    check("rst_out_data",     bus.out_data,          32'd0);
    check("rst_level",        32'(bus.level),        32'd0);
    check("rst_err_ovf",      32'(bus.err_ovf),      32'd0);
    check("rst_err_orphan",   32'(bus.err_orphan),   32'd0);
    bus.up_vld = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rel_up_rdy", 32'(bus.up_rdy), 32'd1);

    // streaming: args 1..20 must come out 1..20 in order
    bus.out_rdy = 1'b1; bus.up_vld = 1'b1; exp_val = 1;
    for (int c = 0; c < 200 && exp_val <= 20; c++) begin
      @(negedge clk);
      if (bus.out_vld) begin
        check("stream_data", bus.out_data, 32'(exp_val));
        exp_val++;
      end
      @(posedge clk); #1;
      if (arg_data > 32'd20) bus.up_vld = 1'b0;
    end
    check("stream_count", 32'(exp_val), 32'd21);
    @(negedge clk);
    check("stream_level",      32'(bus.level),      32'd0);
    check("stream_err_ovf",    32'(bus.err_ovf),    32'd0);
    check("stream_err_orphan", 32'(bus.err_orphan), 32'd0);

    // backpressure: only four issues fit, then credit returns after a pop
    @(posedge clk); #1;
    bus.out_rdy = 1'b0; bus.up_vld = 1'b1; n_iss = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.pipe_arg_vld) n_iss++;
      @(posedge clk); #1;
    end
    bus.up_vld = 1'b0;
    @(negedge clk);
    check("bp_issues",   32'(n_iss),         32'd4);
    check("bp_up_rdy",   32'(bus.up_rdy),    32'd0);
    check("bp_level",    32'(bus.level),     32'd4);
    check("bp_out_data", bus.out_data,       32'd21);
    @(posedge clk); #1; bus.out_rdy = 1'b1;
    @(negedge clk);
    check("bp_up_rdy_pop_cycle", 32'(bus.up_rdy), 32'd0);
    @(posedge clk); #1; bus.out_rdy = 1'b0;
    @(negedge clk);
    check("bp_up_rdy_after_pop", 32'(bus.up_rdy), 32'd1);
    check("bp_level_after_pop",  32'(bus.level),  32'd3);
    check("bp_head_after_pop",   bus.out_data,    32'd22);

    // orphan result with nothing in flight
    @(posedge clk); #1; inj_vld = 1'b1; inj_res = 32'h0BAD;
    @(posedge clk); #1; inj_vld = 1'b0;
    @(negedge clk);
    check("orphan_level",   32'(bus.level),      32'd4);
    check("orphan_flag",    32'(bus.err_orphan), 32'd1);
    check("orphan_err_ovf", 32'(bus.err_ovf),    32'd0);
    check("orphan_up_rdy",  32'(bus.up_rdy),     32'd0);

    // push and pop together while full
    @(posedge clk); #1; inj_vld = 1'b1; inj_res = 32'h0C0D; bus.out_rdy = 1'b1;
    @(negedge clk);
    check("simul_pop_data", bus.out_data, 32'd22);
    @(posedge clk); #1; inj_vld = 1'b0; bus.out_rdy = 1'b0;
    @(negedge clk);
    check("simul_level",   32'(bus.level),   32'd4);
    check("simul_err_ovf", 32'(bus.err_ovf), 32'd0);
    check("simul_head",    bus.out_data,     32'd23);

    // overflow: full, no pop
    @(posedge clk); #1; inj_vld = 1'b1; inj_res = 32'hDEAD;
    @(posedge clk); #1; inj_vld = 1'b0;
    @(negedge clk);
    check("ovf_level", 32'(bus.level),   32'd4);
    check("ovf_flag",  32'(bus.err_ovf), 32'd1);
    check("ovf_head",  bus.out_data,     32'd23);

    // drain: 0xDEAD must not appear
    @(posedge clk); #1; bus.out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_vld",  32'(bus.out_vld), 32'd1);
      check("drain_data", bus.out_data,     drain_exp[i]);
      @(posedge clk); #1;
    end
    bus.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drain_out_vld",      32'(bus.out_vld),    32'd0);
    check("drain_level",        32'(bus.level),      32'd0);
    check("drain_up_rdy",       32'(bus.up_rdy),     32'd1);
    check("drain_ovf_sticky",   32'(bus.err_ovf),    32'd1);
    check("drain_orph_sticky",  32'(bus.err_orphan), 32'd1);

    // mid-stream reset at level 3
    @(posedge clk); #1; bus.up_vld = 1'b1; bus.out_rdy = 1'b0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.level == 3'd3) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("midrst_reach_level3", 32'(found), 32'd1);
    rst = 1'b0; #1;
    check("midrst_level",        32'(bus.level),        32'd0);
    check("midrst_out_vld",      32'(bus.out_vld),      32'd0);
    check("midrst_out_data",     bus.out_data,          32'd0);
    check("midrst_up_rdy",       32'(bus.up_rdy),       32'd0);
    check("midrst_pipe_arg_vld", 32'(bus.pipe_arg_vld), 32'd0);
    bus.up_vld = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_up_rdy",     32'(bus.up_rdy),     32'd1);
    check("post_rst_level",      32'(bus.level),      32'd0);
    check("post_rst_err_ovf",    32'(bus.err_ovf),    32'd0);
    check("post_rst_err_orphan", 32'(bus.err_orphan), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_stale_level", 32'(bus.level),   32'd0);
    check("post_rst_no_stale_vld",   32'(bus.out_vld), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
